// File: rtl/conv_slide_sched_if.sv
// Stream and engine signals of the convolution slide sequencer.
// slave: sequencer view; master: frame source / engine / result sink view.
// All flow control is valid/ready; engine side is start/done pulses.
interface conv_slide_sched_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int PIX_W = 9,
  parameter int OUT_W = 15
);
  localparam int ROW_W = IMG_W * PIX_W;
  localparam int WIN_W = K * ROW_W;
  localparam int RES_W = (IMG_W - K + 1) * OUT_W;
  localparam int IDX_W = $clog2(IMG_H - K + 1);

  logic             frame_start;
  logic             row_in_valid;
  logic             row_in_ready;
  logic [ROW_W-1:0] row_in;
  logic             eng_start;
  logic [WIN_W-1:0] eng_window;
  logic [RES_W-1:0] eng_out;
  logic             eng_done;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic [IDX_W-1:0] res_row_idx;
  logic             busy;
  logic             frame_done;
  logic             err_timeout;

  modport slave (
    input  frame_start, row_in_valid, row_in, eng_out, eng_done, res_ready,
    output row_in_ready, eng_start, eng_window, res_valid, res_data,
           res_row_idx, busy, frame_done, err_timeout
  );

  modport master (
    output frame_start, row_in_valid, row_in, eng_out, eng_done, res_ready,
    input  row_in_ready, eng_start, eng_window, res_valid, res_data,
           res_row_idx, busy, frame_done, err_timeout
  );
endinterface

// File: rtl/conv_slide_sched.sv
// Frame sequencer: 5-row sliding window, one engine start per output row, result stream.
// Latency: eng_start 1 cycle after the completing row handshake; res_valid 1 cycle after eng_done.
// Backpressure: row_in_ready only in FILL; result held in EMIT until res_ready, nothing else advances.
module conv_slide_sched #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 5,
  parameter int PIX_W   = 9,
  parameter int OUT_W   = 15,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  conv_slide_sched_if.slave bus
);
  localparam int ROW_W  = IMG_W * PIX_W;
  localparam int WIN_W  = K * ROW_W;
  localparam int RES_W  = (IMG_W - K + 1) * OUT_W;
  localparam int IDX_W  = $clog2(IMG_H - K + 1);
  localparam int ROWS_W = $clog2(IMG_H + 1);
  localparam int FILL_W = $clog2(K + 1);
  localparam int WD_W   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_START, S_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [WIN_W-1:0]  r_window;
  logic [RES_W-1:0]  r_res_data;
  logic [IDX_W-1:0]  r_res_idx;
  logic [IDX_W-1:0]  r_out_idx;
  logic [ROWS_W-1:0] r_rows_in;
  logic [FILL_W-1:0] r_fill;
  logic [WD_W-1:0]   r_wd;
  logic              r_err;

  logic              w_row_rdy, w_eng_start, w_res_vld, w_busy, w_frame_done;
  logic              w_row_hs, w_fill_last, w_wd_expire, w_last_idx;
  logic [FILL_W-1:0] w_fill_tgt;
  logic [WD_W-1:0]   w_wd_inc;

  // First window needs K fresh rows, every later window slides by one row.
  assign w_fill_tgt  = (r_out_idx == '0) ? FILL_W'(K) : FILL_W'(1);
  assign w_row_hs    = bus.row_in_valid && w_row_rdy;
  assign w_fill_last = ((r_fill + FILL_W'(1)) == w_fill_tgt);
  assign w_wd_inc    = r_wd + WD_W'(1);
  assign w_wd_expire = (w_wd_inc == WD_W'(TIMEOUT - 1));
  assign w_last_idx  = (r_out_idx == IDX_W'(IMG_H - K));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; eng_done has priority over the watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.frame_start) w_next = S_FILL;
      S_FILL:  if (w_row_hs && w_fill_last) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done)      w_next = S_EMIT;
        else if (w_wd_expire)  w_next = S_IDLE;
      end
      S_EMIT:  if (bus.res_ready) w_next = w_last_idx ? S_DONE : S_FILL;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state so reset forces them low immediately.
  always_comb begin
    w_row_rdy    = 1'b0;
    w_eng_start  = 1'b0;
    w_res_vld    = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:  w_busy       = 1'b0;
      S_FILL:  w_row_rdy    = (r_rows_in != ROWS_W'(IMG_H));
      S_START: w_eng_start  = 1'b1;
      S_EMIT:  w_res_vld    = 1'b1;
      S_DONE:  w_frame_done = 1'b1;
      default: ;
    endcase
  end

  // Window, counters, watchdog and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_window   <= '0;
      r_res_data <= '0;
      r_res_idx  <= '0;
      r_out_idx  <= '0;
      r_rows_in  <= '0;
      r_fill     <= '0;
      r_wd       <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rows_in <= '0;
          r_out_idx <= '0;
          r_fill    <= '0;
          if (bus.frame_start) r_err <= 1'b0;
        end
        S_FILL: begin
          if (w_row_hs) begin
            r_window  <= {r_window[WIN_W-ROW_W-1:0], bus.row_in};
            r_rows_in <= r_rows_in + ROWS_W'(1);
            r_fill    <= w_fill_last ? '0 : r_fill + FILL_W'(1);
          end
        end
        S_START: r_wd <= '0;
        S_WAIT: begin
          r_wd <= w_wd_inc;
          if (bus.eng_done) begin
            r_res_data <= bus.eng_out;
            r_res_idx  <= r_out_idx;
          end else if (w_wd_expire) begin
            r_err <= 1'b1;
          end
        end
        S_EMIT: if (bus.res_ready) r_out_idx <= r_out_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.row_in_ready = w_row_rdy;
  assign bus.eng_start    = w_eng_start;
  assign bus.eng_window   = r_window;
  assign bus.res_valid    = w_res_vld;
  assign bus.res_data     = r_res_data;
  assign bus.res_row_idx  = r_res_idx;
  assign bus.busy         = w_busy;
  assign bus.frame_done   = w_frame_done;
  assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_conv_slide_sched.sv
// Directed bench for conv_slide_sched with a simple slide-engine model.
// Engine result column c = (oldest window pixel)*64 + c, so row i expects i*64 + c.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_conv_slide_sched;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int PIX_W = 9;
  localparam int OUT_W = 15;
  localparam int ROW_W = IMG_W * PIX_W;
  localparam int WIN_W = K * ROW_W;
  localparam int NCOL  = IMG_W - K + 1;
  localparam int RES_W = NCOL * OUT_W;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   eng_en   = 1'b1;
  int   eng_lat  = 3;

  int m_rows, m_starts, m_res, m_fd, m_busy_after, m_finished;
  int m_first_old, m_first_new, m_last_old, m_last_new;

  conv_slide_sched_if bus ();

  conv_slide_sched dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1, "tb stalled");
  end

  function automatic logic [ROW_W-1:0] make_row(input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int j = 0; j < IMG_W; j++) v[ROW_W-1-j*PIX_W -: PIX_W] = PIX_W'(r);
    return v;
  endfunction

  function automatic logic [RES_W-1:0] exp_res(input int i);
    logic [RES_W-1:0] v;
    v = '0;
    for (int c = 0; c < NCOL; c++) v[RES_W-1-c*OUT_W -: OUT_W] = OUT_W'(i * 64 + c);
    return v;
  endfunction

  // Engine model: pulses eng_done eng_lat cycles after an observed eng_start.
  initial begin
    logic [PIX_W-1:0] p;
    logic [RES_W-1:0] o;
    bus.eng_done = 1'b0;
    bus.eng_out  = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_start && eng_en) begin
        p = bus.eng_window[WIN_W-1 -: PIX_W];
        o = '0;
        for (int c = 0; c < NCOL; c++) o[RES_W-1-c*OUT_W -: OUT_W] = OUT_W'(int'(p) * 64 + c);
        repeat (eng_lat) @(negedge clk);
        bus.eng_out  = o;
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
      end
    end
  end

  task automatic pulse_frame_start();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // Runs one frame; hold_idx >= 0 stalls res_ready for 10 cycles at that row.
  task automatic run_frame(input int hold_idx, input bit pulse_fs);
    int  next_row, cyc;
    bit  hs, held;
    logic [RES_W-1:0] s_dat;
    logic [4:0]       s_idx;
    m_rows = 0; m_starts = 0; m_res = 0; m_fd = 0; m_finished = 0;
    next_row = 0; cyc = 0; held = 0;
    pulse_frame_start();
    while (!m_finished && cyc < 3000) begin
      cyc++;
      if (hold_idx >= 0 && !held && bus.res_valid && int'(bus.res_row_idx) == hold_idx) begin
        held = 1;
        bus.res_ready = 1'b0;
        s_dat = bus.res_data;
        s_idx = bus.res_row_idx;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          n_checks++;
          if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid k=%0d got %b want 1", k, bus.res_valid); end
          n_checks++;
          if (bus.res_data !== s_dat) begin n_fail++; $display("FAIL hold_data k=%0d changed", k); end
          n_checks++;
          if (bus.res_row_idx !== s_idx) begin n_fail++; $display("FAIL hold_idx k=%0d got %0d want %0d", k, bus.res_row_idx, s_idx); end
          n_checks++;
          if (bus.row_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_row_ready k=%0d got %b want 0", k, bus.row_in_ready); end
          n_checks++;
          if (bus.eng_start !== 1'b0) begin n_fail++; $display("FAIL hold_eng_start k=%0d got %b want 0", k, bus.eng_start); end
        end
      end
      if (bus.eng_start) begin
        m_starts++;
        m_last_old = int'(bus.eng_window[WIN_W-1 -: PIX_W]);
        m_last_new = int'(bus.eng_window[PIX_W-1:0]);
        if (m_starts == 1) begin m_first_old = m_last_old; m_first_new = m_last_new; end
      end
      if (bus.frame_done) begin m_fd++; m_finished = 1; end
      if (bus.res_valid) begin
        n_checks++;
        if (int'(bus.res_row_idx) != m_res) begin n_fail++; $display("FAIL res_idx got %0d want %0d", bus.res_row_idx, m_res); end
        n_checks++;
        if (bus.res_data !== exp_res(m_res)) begin n_fail++; $display("FAIL res_data row %0d got %h want %h", m_res, bus.res_data[RES_W-1 -: 30], exp_res(m_res) >> (RES_W-30)); end
        m_res++;
      end
      bus.row_in_valid = (next_row < IMG_H);
      bus.row_in       = make_row(next_row);
      bus.res_ready    = 1'b1;
      bus.frame_start  = pulse_fs && ((bus.row_in_ready && next_row == 10) ||
                                      (bus.res_valid && bus.res_row_idx == 5'd10));
      hs = bus.row_in_valid && bus.row_in_ready;
      @(negedge clk);
      if (hs) begin next_row++; m_rows++; end
    end
    bus.row_in_valid = 1'b0;
    bus.frame_start  = 1'b0;
    m_busy_after = int'(bus.busy);
  endtask

  // Feeds rows until the first eng_start is seen at a falling edge.
  task automatic feed_until_start(output bit found);
    int r;
    found = 0; r = 0;
    pulse_frame_start();
    for (int c = 0; c < 100 && !found; c++) begin
      if (bus.eng_start) begin
        found = 1;
      end else begin
        bus.row_in_valid = 1'b1;
        bus.row_in       = make_row(r);
        if (bus.row_in_ready) r++;
        @(negedge clk);
      end
    end
    bus.row_in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.row_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_row_ready got %b want 0", bus.row_in_ready); end
    n_checks++; if (bus.eng_start !== 1'b0)    begin n_fail++; $display("FAIL rst_eng_start got %b want 0", bus.eng_start); end
    n_checks++; if (bus.res_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_res_valid got %b want 0", bus.res_valid); end
    n_checks++; if (bus.frame_done !== 1'b0)   begin n_fail++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
    n_checks++; if (bus.err_timeout !== 1'b0)  begin n_fail++; $display("FAIL rst_err got %b want 0", bus.err_timeout); end
    n_checks++; if (bus.eng_window !== '0)     begin n_fail++; $display("FAIL rst_window nonzero"); end
    n_checks++; if (bus.res_data !== '0)       begin n_fail++; $display("FAIL rst_res_data nonzero"); end
    n_checks++; if (bus.res_row_idx !== 5'd0)  begin n_fail++; $display("FAIL rst_res_idx got %0d want 0", bus.res_row_idx); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_full_frame();
    run_frame(-1, 1'b0);
    n_checks++; if (m_finished != 1)  begin n_fail++; $display("FAIL ff_finished got %0d want 1", m_finished); end
    n_checks++; if (m_rows != 28)     begin n_fail++; $display("FAIL ff_rows got %0d want 28", m_rows); end
    n_checks++; if (m_starts != 24)   begin n_fail++; $display("FAIL ff_starts got %0d want 24", m_starts); end
    n_checks++; if (m_res != 24)      begin n_fail++; $display("FAIL ff_results got %0d want 24", m_res); end
    n_checks++; if (m_fd != 1)        begin n_fail++; $display("FAIL ff_frame_done got %0d want 1", m_fd); end
    n_checks++; if (m_busy_after != 0) begin n_fail++; $display("FAIL ff_busy_after got %0d want 0", m_busy_after); end
  endtask

  task automatic test_window_order();
    n_checks++; if (m_first_old != 0)  begin n_fail++; $display("FAIL win_first_old got %0d want 0", m_first_old); end
    n_checks++; if (m_first_new != 4)  begin n_fail++; $display("FAIL win_first_new got %0d want 4", m_first_new); end
    n_checks++; if (m_last_old != 23)  begin n_fail++; $display("FAIL win_last_old got %0d want 23", m_last_old); end
    n_checks++; if (m_last_new != 27)  begin n_fail++; $display("FAIL win_last_new got %0d want 27", m_last_new); end
  endtask

  task automatic test_res_backpressure();
    run_frame(5, 1'b0);
    n_checks++; if (m_res != 24) begin n_fail++; $display("FAIL bp_results got %0d want 24", m_res); end
    n_checks++; if (m_fd != 1)   begin n_fail++; $display("FAIL bp_frame_done got %0d want 1", m_fd); end
  endtask

  task automatic test_timeout();
    bit found;
    int n;
    eng_en = 1'b0;
    feed_until_start(found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL to_start_seen got 0 want 1"); end
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.err_timeout === 1'b1) begin n = i; break; end
    end
    n_checks++; if (n != 64)             begin n_fail++; $display("FAIL to_cycles got %0d want 64", n); end
    n_checks++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL to_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL to_res_valid got %b want 0", bus.res_valid); end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", bus.err_timeout); end
    pulse_frame_start();
    n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b want 0", bus.err_timeout); end
    n_checks++; if (bus.busy !== 1'b1)        begin n_fail++; $display("FAIL to_restart_busy got %b want 1", bus.busy); end
    apply_reset();
    eng_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    eng_en = 1'b0;
    feed_until_start(found);
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mw_busy_before got %b want 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL mw_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.res_valid !== 1'b0)   begin n_fail++; $display("FAIL mw_res_valid got %b want 0", bus.res_valid); end
    n_checks++; if (bus.eng_start !== 1'b0)   begin n_fail++; $display("FAIL mw_eng_start got %b want 0", bus.eng_start); end
    n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL mw_err got %b want 0", bus.err_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    eng_en = 1'b1;
    @(negedge clk);
    run_frame(-1, 1'b0);
    n_checks++; if (m_res != 24) begin n_fail++; $display("FAIL mw_results got %0d want 24", m_res); end
    n_checks++; if (m_fd != 1)   begin n_fail++; $display("FAIL mw_frame_done got %0d want 1", m_fd); end
  endtask

  task automatic test_frame_start_ignored();
    run_frame(-1, 1'b1);
    n_checks++; if (m_rows != 28)   begin n_fail++; $display("FAIL fs_rows got %0d want 28", m_rows); end
    n_checks++; if (m_starts != 24) begin n_fail++; $display("FAIL fs_starts got %0d want 24", m_starts); end
    n_checks++; if (m_res != 24)    begin n_fail++; $display("FAIL fs_results got %0d want 24", m_res); end
    n_checks++; if (m_fd != 1)      begin n_fail++; $display("FAIL fs_frame_done got %0d want 1", m_fd); end
  endtask

  initial begin
    bus.frame_start  = 1'b0;
    bus.row_in_valid = 1'b0;
    bus.row_in       = '0;
    bus.res_ready    = 1'b1;
    rst_n            = 1'b0;
    test_reset();
    test_full_frame();
    test_window_order();
    test_res_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_frame_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
